// File: rtl/fetch_pkg.sv
// Shared types and field positions for the dual-issue fetch path.
// Also holds the perf-counter saturating increment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_HALT   = 2'd2
  } fetch_state_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dual_issue_fetch_ctrl_if.sv
// Fetch-side bundle: instruction memory, redirect and issue slots.
// master = fetch controller, slave = memory/decode environment.
interface dual_issue_fetch_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] inst_address;
  logic [31:0]       instruction1;
  logic [31:0]       instruction2;
  logic              issue_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              issue0_valid;
  logic [31:0]       issue0_inst;
  logic [ADDR_W-1:0] issue0_pc;
  logic              issue1_valid;
  logic [31:0]       issue1_inst;
  logic [ADDR_W-1:0] issue1_pc;
  logic              halted;

  modport master (
    output inst_address,
    input  instruction1,
    input  instruction2,
    input  issue_ready,
    input  redirect_valid,
    input  redirect_pc,
    output issue0_valid,
    output issue0_inst,
    output issue0_pc,
    output issue1_valid,
    output issue1_inst,
    output issue1_pc,
    output halted
  );

  modport slave (
    input  inst_address,
    output instruction1,
    output instruction2,
    output issue_ready,
    output redirect_valid,
    output redirect_pc,
    input  issue0_valid,
    input  issue0_inst,
    input  issue0_pc,
    input  issue1_valid,
    input  issue1_inst,
    input  issue1_pc,
    input  halted
  );
endinterface

// File: rtl/pair_hazard_chk.sv
// Intra-pair dependency check: does inst2 touch the register inst1 writes?
// Purely combinational.
module pair_hazard_chk
  import fetch_pkg::*;
(
  input  logic [31:0] inst1_i,
  input  logic [31:0] inst2_i,
  output logic        dep_o
);

  logic [4:0] rd1;
  logic [4:0] rd2;
  logic [4:0] rs1_2;
  logic [4:0] rs2_2;
  logic [6:0] opc2;
  logic       uses_rs2;

  assign rd1   = inst1_i[RD_MSB:RD_LSB];
  assign rd2   = inst2_i[RD_MSB:RD_LSB];
  assign rs1_2 = inst2_i[RS1_MSB:RS1_LSB];
  assign rs2_2 = inst2_i[RS2_MSB:RS2_LSB];
  assign opc2  = inst2_i[OPC_MSB:OPC_LSB];

  // Unknown opcodes are assumed to read both sources.
  always_comb begin
    uses_rs2 = 1'b1;
    unique case (1'b1)
      (opc2 == OPC_OP_IMM): uses_rs2 = 1'b0;
      (opc2 == OPC_OP):     uses_rs2 = 1'b1;
      default:              uses_rs2 = 1'b1;
    endcase
  end

  assign dep_o = (rd1 != 5'd0) &&
                 ((rs1_2 == rd1) ||
                  (uses_rs2 && (rs2_2 == rd1)) ||
                  (rd2 == rd1));

endmodule

// File: rtl/dual_issue_fetch_ctrl.sv
// Dual-issue fetch sequencer: PC, pair issue, redirect and halt.
// Define DIF_PERF_CNT_EN to add dual/single/stall counters.
module dual_issue_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int PROG_BYTES = 116
) (
  input  logic clk,
  input  logic rst_n,
  dual_issue_fetch_ctrl_if.master bus
`ifdef DIF_PERF_CNT_EN
  ,
  output logic [15:0] dual_cnt,
  output logic [15:0] single_cnt,
  output logic [15:0] stall_cnt
`endif
);

  localparam int            AW1    = ADDR_W + 1;
  localparam logic [AW1-1:0] END_PC = AW1'(PROG_BYTES);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              v0_q;
  logic [31:0]       i0_q;
  logic [ADDR_W-1:0] p0_q;
  logic              v1_q;
  logic [31:0]       i1_q;
  logic [ADDR_W-1:0] p1_q;
  logic              halted_q;

  logic              dep;
  logic              at_end;
  logic              tail;
  logic              dual_ok;
  logic              run_go;
  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] pc8;

  pair_hazard_chk u_hz (
    .inst1_i (bus.instruction1),
    .inst2_i (bus.instruction2),
    .dep_o   (dep)
  );

  assign pc4     = pc_q + ADDR_W'(4);
  assign pc8     = pc_q + ADDR_W'(8);
  assign at_end  = {1'b0, pc_q} >= END_PC;
  assign tail    = ({1'b0, pc_q} + AW1'(4)) >= END_PC;
  assign dual_ok = !dep && !tail;
  assign run_go  = (state_q == ST_RUN) &&
                   bus.issue_ready &&
                   !bus.redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      pc_q     <= '0;
      v0_q     <= 1'b0;
      i0_q     <= '0;
      p0_q     <= '0;
      v1_q     <= 1'b0;
      i1_q     <= '0;
      p1_q     <= '0;
      halted_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc_q     <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      state_q  <= ST_BUBBLE;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_BUBBLE: state_q <= ST_RUN;
        ST_HALT:   state_q <= ST_HALT;
        ST_RUN: begin
          if (bus.issue_ready) begin
            if (at_end) begin
              v0_q     <= 1'b0;
              v1_q     <= 1'b0;
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end else begin
              v0_q <= 1'b1;
              i0_q <= bus.instruction1;
              p0_q <= pc_q;
              // A tail single issue lands pc on the end; HALT follows.
              if (dual_ok) begin
                v1_q <= 1'b1;
                i1_q <= bus.instruction2;
                p1_q <= pc4;
                pc_q <= pc8;
              end else begin
                v1_q <= 1'b0;
                pc_q <= pc4;
              end
            end
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign bus.inst_address = pc_q;
  assign bus.issue0_valid = v0_q;
  assign bus.issue0_inst  = i0_q;
  assign bus.issue0_pc    = p0_q;
  assign bus.issue1_valid = v1_q;
  assign bus.issue1_inst  = i1_q;
  assign bus.issue1_pc    = p1_q;
  assign bus.halted       = halted_q;

`ifdef DIF_PERF_CNT_EN
  logic [15:0] dual_q;
  logic [15:0] single_q;
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dual_q   <= '0;
      single_q <= '0;
      stall_q  <= '0;
    end else begin
      if (run_go && !at_end) begin
        if (dual_ok) dual_q <= sat_inc16(dual_q);
        else         single_q <= sat_inc16(single_q);
      end
      if ((state_q == ST_RUN) &&
          !bus.issue_ready &&
          !bus.redirect_valid)
        stall_q <= sat_inc16(stall_q);
    end
  end

  assign dual_cnt   = dual_q;
  assign single_cnt = single_q;
  assign stall_cnt  = stall_q;
`else
  logic unused_run_go;
  assign unused_run_go = run_go;
`endif

endmodule

// File: tb/tb_dual_issue_fetch_ctrl.sv
// Directed bench for dual_issue_fetch_ctrl: vector table + corner sequences.
// Second instance uses PROG_BYTES=112 for the odd tail.
module tb_dual_issue_fetch_ctrl;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dual_issue_fetch_ctrl_if #(.ADDR_W(8)) ifa ();
  dual_issue_fetch_ctrl_if #(.ADDR_W(8)) ifb ();

  logic [31:0] mem [64];
  logic [5:0]  a_nx;
  logic [5:0]  b_nx;

  assign a_nx = ifa.inst_address[7:2] + 6'd1;
  assign b_nx = ifb.inst_address[7:2] + 6'd1;
  assign ifa.instruction1 = mem[ifa.inst_address[7:2]];
  assign ifa.instruction2 = mem[a_nx];
  assign ifb.instruction1 = mem[ifb.inst_address[7:2]];
  assign ifb.instruction2 = mem[b_nx];

`ifdef DIF_PERF_CNT_EN
  logic [15:0] a_dual, a_single, a_stall;
  logic [15:0] b_dual, b_single, b_stall;
`endif

  dual_issue_fetch_ctrl #(
    .ADDR_W(8), .PROG_BYTES(116)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.master)
`ifdef DIF_PERF_CNT_EN
    ,
    .dual_cnt   (a_dual),
    .single_cnt (a_single),
    .stall_cnt  (a_stall)
`endif
  );

  dual_issue_fetch_ctrl #(
    .ADDR_W(8), .PROG_BYTES(112)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.master)
`ifdef DIF_PERF_CNT_EN
    ,
    .dual_cnt   (b_dual),
    .single_cnt (b_single),
    .stall_cnt  (b_stall)
`endif
  );

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [7:0]  rpc;
    logic        v0;
    logic [31:0] i0;
    logic [7:0]  p0;
    logic        v1;
    logic [31:0] i1;
    logic [7:0]  p1;
    logic        hl;
    logic [7:0]  pc;
  } vec_t;

  vec_t vt[$];
  int   total = 0;
  int   passed = 0;

  task automatic add(
    input logic rdy, input logic rv,
    input logic [7:0] rpc,
    input logic v0, input logic [31:0] i0,
    input logic [7:0] p0,
    input logic v1, input logic [31:0] i1,
    input logic [7:0] p1,
    input logic hl, input logic [7:0] pc
  );
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.v0 = v0; v.i0 = i0; v.p0 = p0;
    v.v1 = v1; v.i1 = i1; v.p1 = p1;
    v.hl = hl; v.pc = pc;
    vt.push_back(v);
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chk_a(input string tag, input vec_t v);
    chk({tag, " v0"}, 32'(ifa.issue0_valid), 32'(v.v0));
    chk({tag, " v1"}, 32'(ifa.issue1_valid), 32'(v.v1));
    chk({tag, " halted"}, 32'(ifa.halted), 32'(v.hl));
    chk({tag, " pc"}, 32'(ifa.inst_address), 32'(v.pc));
    if (v.v0) begin
      chk({tag, " i0"}, ifa.issue0_inst, v.i0);
      chk({tag, " p0"}, 32'(ifa.issue0_pc), 32'(v.p0));
    end
    if (v.v1) begin
      chk({tag, " i1"}, ifa.issue1_inst, v.i1);
      chk({tag, " p1"}, 32'(ifa.issue1_pc), 32'(v.p1));
    end
  endtask

  task automatic chk_b(
    input string tag, input logic v0,
    input logic [31:0] i0, input logic [7:0] p0,
    input logic v1, input logic [31:0] i1,
    input logic hl, input logic [7:0] pc
  );
    chk({tag, " v0"}, 32'(ifb.issue0_valid), 32'(v0));
    chk({tag, " v1"}, 32'(ifb.issue1_valid), 32'(v1));
    chk({tag, " halted"}, 32'(ifb.halted), 32'(hl));
    chk({tag, " pc"}, 32'(ifb.inst_address), 32'(pc));
    if (v0) begin
      chk({tag, " i0"}, ifb.issue0_inst, i0);
      chk({tag, " p0"}, 32'(ifb.issue0_pc), 32'(p0));
    end
    if (v1) chk({tag, " i1"}, ifb.issue1_inst, i1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hv;
    for (int k = 0; k < 64; k++) mem[k] = 32'h0;
    mem[0]  = 32'h00a00093; mem[1]  = 32'h01400113;
    mem[2]  = 32'h01e00193; mem[3]  = 32'h02800213;
    mem[4]  = 32'h00110113; mem[5]  = 32'h00208333;
    mem[6]  = 32'h403203b3; mem[7]  = 32'h00000013;
    mem[8]  = 32'h00000033; mem[9]  = 32'h00100413;
    mem[10] = 32'h0030c533; mem[11] = 32'h000095b3;
    mem[12] = 32'h00b00613; mem[13] = 32'h00200713;
    mem[14] = 32'h00300793; mem[15] = 32'h000016b7;
    mem[16] = 32'h00d02023; mem[17] = 32'h00400813;
    mem[18] = 32'h00500893; mem[19] = 32'h00600913;
    mem[20] = 32'h00700993; mem[21] = 32'h00800a13;
    mem[22] = 32'h00f00b93; mem[23] = 32'h00abfc13;
    mem[24] = 32'h014bec93; mem[25] = 32'h00900a93;
    mem[26] = 32'h00a00b13; mem[27] = 32'h001bde13;
    mem[28] = 32'h014bae93;

    add(1,0,0, 1,32'h00a00093,0,  1,32'h01400113,4,  0,8);
    add(1,0,0, 1,32'h01e00193,8,  1,32'h02800213,12, 0,16);
    add(1,0,0, 1,32'h00110113,16, 0,0,0,             0,20);
    add(0,0,0, 1,32'h00110113,16, 0,0,0,             0,20);
    add(0,0,0, 1,32'h00110113,16, 0,0,0,             0,20);
    add(0,0,0, 1,32'h00110113,16, 0,0,0,             0,20);
    add(1,0,0, 1,32'h00208333,20, 1,32'h403203b3,24, 0,28);
    add(1,0,0, 1,32'h00000013,28, 1,32'h00000033,32, 0,36);
    add(1,0,0, 1,32'h00100413,36, 1,32'h0030c533,40, 0,44);
    add(1,0,0, 1,32'h000095b3,44, 1,32'h00b00613,48, 0,52);
    add(1,0,0, 1,32'h00200713,52, 1,32'h00300793,56, 0,60);
    add(1,0,0, 1,32'h000016b7,60, 0,0,0,             0,64);
    add(1,0,0, 1,32'h00d02023,64, 1,32'h00400813,68, 0,72);
    add(1,0,0, 1,32'h00500893,72, 1,32'h00600913,76, 0,80);
    add(1,0,0, 1,32'h00700993,80, 1,32'h00800a13,84, 0,88);
    add(1,0,0, 1,32'h00f00b93,88, 0,0,0,             0,92);
    add(1,0,0, 1,32'h00abfc13,92, 1,32'h014bec93,96, 0,100);
    add(1,0,0, 1,32'h00900a93,100,1,32'h00a00b13,104,0,108);
    add(1,0,0, 1,32'h001bde13,108,1,32'h014bae93,112,0,116);
    add(1,0,0, 0,0,0, 0,0,0, 1,116);
    add(1,0,0, 0,0,0, 0,0,0, 1,116);
    add(0,0,0, 0,0,0, 0,0,0, 1,116);
    add(1,1,8'h2b, 0,0,0, 0,0,0, 0,8'h28);
    add(1,0,0, 0,0,0, 0,0,0, 0,8'h28);
    add(1,0,0, 1,32'h0030c533,40, 1,32'h000095b3,44, 0,48);
    add(1,0,0, 1,32'h00b00613,48, 1,32'h00200713,52, 0,56);
    add(0,1,8'h00, 0,0,0, 0,0,0, 0,0);
    add(1,0,0, 0,0,0, 0,0,0, 0,0);
    add(1,0,0, 1,32'h00a00093,0,  1,32'h01400113,4,  0,8);

    ifa.issue_ready = 1'b1;
    ifa.redirect_valid = 1'b0;
    ifa.redirect_pc = 8'h0;
    ifb.issue_ready = 1'b1;
    ifb.redirect_valid = 1'b0;
    ifb.redirect_pc = 8'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst v0", 32'(ifa.issue0_valid), 32'd0);
    chk("rst v1", 32'(ifa.issue1_valid), 32'd0);
    chk("rst halted", 32'(ifa.halted), 32'd0);
    chk("rst pc", 32'(ifa.inst_address), 32'd0);
    chk("rst i0", ifa.issue0_inst, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      ifa.issue_ready    = vt[i].rdy;
      ifa.redirect_valid = vt[i].rv;
      ifa.redirect_pc    = vt[i].rpc;
      @(posedge clk);
      #1;
      chk_a($sformatf("vec%0d", i), vt[i]);
`ifdef DIF_PERF_CNT_EN
      if (i == 6) begin
        chk("stall_cnt", 32'(a_stall), 32'd3);
        chk("dual_cnt", 32'(a_dual), 32'd3);
        chk("single_cnt", 32'(a_single), 32'd1);
      end
`endif
    end

    // Async reset in the middle of a run at pc=60.
    ifa.issue_ready = 1'b1;
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc = 8'd52;
    @(posedge clk); #1;
    ifa.redirect_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    hv = '{1,0,0, 1,32'h00200713,52, 1,32'h00300793,56, 0,60};
    chk_a("pre-rst", hv);
    #2;
    rst_n = 1'b0;
    #1;
    hv = '{1,0,0, 0,0,0, 0,0,0, 0,0};
    chk_a("async-rst", hv);
    chk("async-rst i0", ifa.issue0_inst, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    hv = '{1,0,0, 1,32'h00a00093,0, 1,32'h01400113,4, 0,8};
    chk_a("post-rst", hv);
`ifdef DIF_PERF_CNT_EN
    chk("post-rst dual_cnt", 32'(a_dual), 32'd1);
    chk("post-rst stall_cnt", 32'(a_stall), 32'd0);
`endif

    // PROG_BYTES=112: 108 becomes a tail single issue.
    ifb.redirect_valid = 1'b1;
    ifb.redirect_pc = 8'd100;
    @(posedge clk); #1;
    ifb.redirect_valid = 1'b0;
    chk_b("b redir", 0,0,0, 0,0, 0,100);
    @(posedge clk); #1;
    chk_b("b bubble", 0,0,0, 0,0, 0,100);
    @(posedge clk); #1;
    chk_b("b dual", 1,32'h00900a93,100,
          1,32'h00a00b13, 0,108);
    chk("b p1", 32'(ifb.issue1_pc), 32'd104);
    @(posedge clk); #1;
    chk_b("b tail", 1,32'h001bde13,108,
          0,0, 0,112);
    @(posedge clk); #1;
    chk_b("b halt", 0,0,0, 0,0, 1,112);
    @(posedge clk); #1;
    chk_b("b halt2", 0,0,0, 0,0, 1,112);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
